conv_frame_ctrl: RTL and testbench
==================================

Name: conv_frame_ctrl

Overview:
- Sequencer and configuration controller for the 3x3 RGB convolution datapath on the 320x240 camera stream.
- Watches the input-side stream handshake and tracks frame position and window warm-up.
- Drives the datapath's output-enable (conv_ready), the nine kernel coefficients and the normalisation shift.
- Allows a user kernel change only at frame boundaries, so one frame is never filtered with mixed kernels.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- BW, 8, signed coefficient width.
- PRIME_LEN, 2*WIDTH+3, transfers needed to fill the line-buffer window.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  datapath input valid.
- in_ready  in  1  datapath input ready; a transfer occurs when in_valid & in_ready.
- mode_sel  in  2  requested kernel: 0 identity, 1 gaussian, 2 edge, 3 sharpen.
- coeff  out  9*BW  kernel taps h[0..8]; h[0] in the LSBs, two's complement.
- shift  out  4  right-shift applied to the MAC result.
- active_mode  out  2  kernel currently applied.
- conv_ready  out  1  window full; datapath may emit results.
- border  out  1  current window centre is in column 0 or column WIDTH-1 (window wraps across lines).
- sof  out  1  one-cycle pulse; the first transfer of a frame occurred.
- eof  out  1  one-cycle pulse; the last transfer of a frame occurred.
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-frame) forces:
  - state IDLE, pix_cnt 0, ctr_col 0, ctr_row 0;
  - active_mode 0, so coeff = identity and shift 0;
  - conv_ready 0, border 0, sof 0, eof 0, frame_cnt 0.
- After rst_n deasserts, the first transfer is treated as frame pixel 0.
- pix_cnt (clog2(WIDTH*HEIGHT) bits) counts transfers in the current frame. It advances only on a transfer.
- With no transfer (valid low or ready low), every register holds, except that sof and eof clear to 0.
- States:
  - IDLE: on transfer -> PRIME; sof=1; pix_cnt=1. While in IDLE, active_mode follows mode_sel every cycle.
  - PRIME: conv_ready=0. On the transfer where pix_cnt==PRIME_LEN-1 -> RUN; conv_ready=1; ctr_col=1; ctr_row=1.
  - RUN: conv_ready=1. Each transfer advances the centre position:
    - ctr_col+1; at WIDTH-1 it wraps to 0 and ctr_row increments.
    - border = (next ctr_col==0) || (next ctr_col==WIDTH-1), registered with the counters.
  - Frame wrap, in PRIME or RUN, on the transfer where pix_cnt==WIDTH*HEIGHT-1:
    - pix_cnt=0, next state PRIME, conv_ready=0, border=0;
    - eof=1, frame_cnt+1;
    - active_mode=mode_sel as sampled on that cycle.
  - After a wrap, the next transfer (pix_cnt==0) gives sof=1 and stays in PRIME.
- Wrap has priority over the PRIME->RUN check. This only matters for degenerate sizes where WIDTH*HEIGHT <= PRIME_LEN: such frames never reach RUN.
- Latency:
  - conv_ready rises in the cycle after the PRIME_LEN-th transfer.
  - coeff and shift change only in the cycle after an eof transfer, or in IDLE. They are stable for the whole frame.
- mode_sel changes mid-frame are ignored until the wrap. Only the value present on the wrap cycle is used; intermediate values are discarded.
- Kernel table (h0..h8; shift):
  - 0: 0,0,0,0,1,0,0,0,0; shift 0.
  - 1: 1,2,1,2,4,2,1,2,1; shift 4.
  - 2: -1,-1,-1,-1,8,-1,-1,-1,-1; shift 0.
  - 3: 0,-1,0,-1,5,-1,0,-1,0; shift 0.
- Coefficients are sign-extended to BW.
- Saturation and clamping of the result belong to the datapath, not this block.
- At the final RUN transfer of a frame, the centre is at (row HEIGHT-2, col WIDTH-2). Row 0 and row HEIGHT-1 are never centres.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=6, so PRIME_LEN=19 and a frame is 48 transfers.
- Reset then 48 back-to-back transfers, mode_sel=1 held:
  - sof on the cycle after transfer 1;
  - conv_ready=1 from the cycle after transfer 19;
  - eof after transfer 48; frame_cnt=1; conv_ready=0;
  - active_mode=1 throughout, since it is taken in IDLE.
- Random in_valid/in_ready gaps (about 50% duty): counts, pulses and frame_cnt are identical to the gapless run. No state advance occurs on any non-transfer cycle.
- Centre tracking across one frame:
  - ctr (1,1) at RUN entry;
  - border=1 exactly when ctr_col is 0 or 7;
  - last centre is (4,6).
- mode_sel toggles 1->3->2 mid-frame, ending at 2 on the wrap cycle:
  - coeff stays gaussian until eof;
  - then edge taps (8 at the centre, -1 elsewhere) with shift=0.
- rst_n pulsed low at transfer 30 of a frame: all outputs reset asynchronously, before the next clk edge. The next transfer gives sof=1 and pix_cnt=1.
- 65536 frames (forced via a shortened-frame run or a counter preload): frame_cnt wraps 65535 -> 0 with eof=1.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer and kernel configuration for the 3x3 RGB
// convolution datapath. Counts input transfers, tracks window warm-up and the
// window centre, and switches kernels only at frame boundaries.
module conv_frame_ctrl #(
   parameter int WIDTH     = 320,
   parameter int HEIGHT    = 240,
   parameter int BW        = 8,
   parameter int PRIME_LEN = 2*WIDTH+3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            in_ready,
   input  logic [1:0]      mode_sel,
   output logic [9*BW-1:0] coeff,
   output logic [3:0]      shift,
   output logic [1:0]      active_mode,
   output logic            conv_ready,
   output logic            border,
   output logic            sof,
   output logic            eof,
   output logic [15:0]     frame_cnt
);

   localparam int NPIX = WIDTH*HEIGHT;
   localparam int PW   = (NPIX > 1)   ? $clog2(NPIX)   : 1;
   localparam int CW   = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
   localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [PW-1:0] LAST_PIX   = PW'(NPIX-1);
   localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_LEN-1);
   localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH-1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Kernel taps for a mode; h[0] lands in the LSBs, negatives sign-extended to BW.
   function automatic logic [9*BW-1:0] kernel_coeff(input logic [1:0] mode);
      int taps [9];
      case (mode)
         2'd1:    taps = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
         2'd2:    taps = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
         2'd3:    taps = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
         default: taps = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      endcase
      kernel_coeff = '0;
      for (int i = 0; i < 9; i++) begin
         kernel_coeff[i*BW +: BW] = BW'(taps[i]);
      end
   endfunction

   // Normalisation shift for a mode; only the gaussian needs scaling (sum 16).
   function automatic logic [3:0] kernel_shift(input logic [1:0] mode);
      case (mode)
         2'd1:    kernel_shift = 4'd4;
         default: kernel_shift = 4'd0;
      endcase
   endfunction

   state_t          r_state;
   logic [PW-1:0]   r_pix_cnt;
   logic [CW-1:0]   r_ctr_col;
   logic [RW-1:0]   r_ctr_row;
   logic [1:0]      r_active_mode;
   logic [9*BW-1:0] r_coeff;
   logic [3:0]      r_shift;
   logic            r_conv_ready;
   logic            r_border;
   logic            r_sof;
   logic            r_eof;
   logic [15:0]     r_frame_cnt;

   logic            w_xfer;
   logic            w_wrap;
   logic            w_col_end;
   logic [CW-1:0]   w_col_nx;
   logic [RW-1:0]   w_row_nx;
   logic            w_border_nx;

   assign w_xfer      = in_valid & in_ready;
   assign w_wrap      = (r_pix_cnt == LAST_PIX);
   assign w_col_end   = (r_ctr_col == COL_LAST);
   assign w_col_nx    = w_col_end ? '0 : (r_ctr_col + CW'(1));
   assign w_row_nx    = w_col_end ? (r_ctr_row + RW'(1)) : r_ctr_row;
   assign w_border_nx = (w_col_nx == '0) || (w_col_nx == COL_LAST);

   // Frame sequencer: state, counters, pulses and kernel selection in one place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_pix_cnt     <= '0;
         r_ctr_col     <= '0;
         r_ctr_row     <= '0;
         r_active_mode <= 2'd0;
         r_coeff       <= kernel_coeff(2'd0);
         r_shift       <= 4'd0;
         r_conv_ready  <= 1'b0;
         r_border      <= 1'b0;
         r_sof         <= 1'b0;
         r_eof         <= 1'b0;
         r_frame_cnt   <= 16'd0;
      end else begin
         r_sof <= 1'b0;
         r_eof <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // No frame in flight yet, so the kernel may track the request freely.
               r_active_mode <= mode_sel;
               r_coeff       <= kernel_coeff(mode_sel);
               r_shift       <= kernel_shift(mode_sel);
               if (w_xfer) begin
                  r_state   <= ST_PRIME;
                  r_sof     <= 1'b1;
                  r_pix_cnt <= PW'(1);
               end
            end
            ST_PRIME, ST_RUN: begin
               if (w_xfer) begin
                  r_sof <= (r_pix_cnt == '0);
                  // The centre keeps moving on the closing transfer so it ends at (H-2, W-2).
                  if (r_state == ST_RUN) begin
                     r_ctr_col <= w_col_nx;
                     r_ctr_row <= w_row_nx;
                  end
                  if (w_wrap) begin
                     // Frame boundary outranks warm-up; the kernel is latched here only.
                     r_state       <= ST_PRIME;
                     r_pix_cnt     <= '0;
                     r_conv_ready  <= 1'b0;
                     r_border      <= 1'b0;
                     r_eof         <= 1'b1;
                     r_frame_cnt   <= r_frame_cnt + 16'd1;
                     r_active_mode <= mode_sel;
                     r_coeff       <= kernel_coeff(mode_sel);
                     r_shift       <= kernel_shift(mode_sel);
                  end else if ((r_state == ST_PRIME) && (r_pix_cnt == PRIME_LAST)) begin
                     // Window just filled: first valid centre is (1,1).
                     r_state      <= ST_RUN;
                     r_pix_cnt    <= r_pix_cnt + PW'(1);
                     r_conv_ready <= 1'b1;
                     r_ctr_col    <= CW'(1);
                     r_ctr_row    <= RW'(1);
                     r_border     <= (COL_LAST == CW'(1));
                  end else begin
                     r_pix_cnt <= r_pix_cnt + PW'(1);
                     if (r_state == ST_RUN) begin
                        r_border <= w_border_nx;
                     end else begin
                        r_border <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign coeff       = r_coeff;
   assign shift       = r_shift;
   assign active_mode = r_active_mode;
   assign conv_ready  = r_conv_ready;
   assign border      = r_border;
   assign sof         = r_sof;
   assign eof         = r_eof;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl on an 8x6 frame (PRIME_LEN 19, 48 transfers).
module tb_conv_frame_ctrl;

   localparam int W     = 8;
   localparam int H     = 6;
   localparam int BW    = 8;
   localparam int PRIME = 2*W+3;
   localparam int FRAME = W*H;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready = 1'b0;
   logic [1:0]      mode_sel = 2'd0;
   logic [9*BW-1:0] coeff;
   logic [3:0]      shift;
   logic [1:0]      active_mode;
   logic            conv_ready;
   logic            border;
   logic            sof;
   logic            eof;
   logic [15:0]     frame_cnt;

   conv_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .BW(BW), .PRIME_LEN(PRIME)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode_sel(mode_sel), .coeff(coeff), .shift(shift), .active_mode(active_mode),
      .conv_ready(conv_ready), .border(border), .sof(sof), .eof(eof),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sof, eof, conv, border;
      logic [1:0]  mode;
      logic [15:0] fcnt;
      int          pos;
      bit          ctr_chk;
      int          col, row;
   } exp_t;

   exp_t sb [$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state: frame position counted in whole transfers.
   bit          m_started;
   int          m_pos;
   logic [1:0]  m_mode;
   logic [15:0] m_fcnt;
   bit          m_conv, m_border;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [71:0] ref_coeff(input logic [1:0] m);
      int t [9];
      logic [71:0] r;
      case (m)
         2'd1:    t = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
         2'd2:    t = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
         2'd3:    t = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
         default: t = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      endcase
      r = '0;
      for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(t[i]);
      return r;
   endfunction

   function automatic logic [3:0] ref_shift(input logic [1:0] m);
      return (m == 2'd1) ? 4'd4 : 4'd0;
   endfunction

   task automatic model_reset();
      m_started = 1'b0; m_pos = 0; m_mode = 2'd0; m_fcnt = 16'd0;
      m_conv = 1'b0; m_border = 1'b0;
   endtask

   // Advance the model one clock and queue the outputs expected after that edge.
   task automatic model_step(input bit x, input logic [1:0] ms);
      exp_t e;
      int   k, lin;
      e.sof = 1'b0; e.eof = 1'b0; e.ctr_chk = 1'b0; e.col = 0; e.row = 0;
      if (!m_started) begin
         m_mode = ms;
         if (x) begin
            m_started = 1'b1; m_pos = 1; e.sof = 1'b1;
         end
      end else if (x) begin
         k = m_pos + 1;                 // 1-based index of this transfer in the frame
         if (m_pos == 0) e.sof = 1'b1;
         if (k >= PRIME) begin          // centre = pixel received W+1 transfers ago
            lin = k - 1 - (W + 1);
            e.ctr_chk = 1'b1; e.col = lin % W; e.row = lin / W;
         end
         if (k == FRAME) begin
            e.eof = 1'b1; m_fcnt = m_fcnt + 16'd1; m_mode = ms;
            m_pos = 0; m_conv = 1'b0; m_border = 1'b0;
         end else begin
            m_pos = k;
            m_conv = (k >= PRIME);
            m_border = m_conv && ((e.col == 0) || (e.col == W-1));
         end
      end
      e.conv = m_conv; e.border = m_border; e.mode = m_mode;
      e.fcnt = m_fcnt; e.pos = m_pos;
      sb.push_back(e);
   endtask

   task automatic step(input bit v, input bit r, input logic [1:0] ms);
      @(negedge clk);
      in_valid = v; in_ready = r; mode_sel = ms;
      model_step(v && r, ms);
   endtask

   task automatic chk_reset_state();
      chk("rst_conv_ready", 72'(conv_ready), 72'(0));
      chk("rst_border", 72'(border), 72'(0));
      chk("rst_sof", 72'(sof), 72'(0));
      chk("rst_eof", 72'(eof), 72'(0));
      chk("rst_frame_cnt", 72'(frame_cnt), 72'(0));
      chk("rst_active_mode", 72'(active_mode), 72'(0));
      chk("rst_coeff", coeff, ref_coeff(2'd0));
      chk("rst_shift", 72'(shift), 72'(0));
   endtask

   // Monitor: each edge that has a queued expectation is checked 2 ns later.
   exp_t me;
   always @(posedge clk) begin
      if (sb.size() > 0) begin
         me = sb.pop_front();
         #2;
         chk("sof", 72'(sof), 72'(me.sof));
         chk("eof", 72'(eof), 72'(me.eof));
         chk("conv_ready", 72'(conv_ready), 72'(me.conv));
         chk("border", 72'(border), 72'(me.border));
         chk("active_mode", 72'(active_mode), 72'(me.mode));
         chk("coeff", coeff, ref_coeff(me.mode));
         chk("shift", 72'(shift), 72'(ref_shift(me.mode)));
         chk("frame_cnt", 72'(frame_cnt), 72'(me.fcnt));
         chk("pix_cnt", 72'(dut.r_pix_cnt), 72'(me.pos));
         if (me.ctr_chk) begin
            chk("ctr_col", 72'(dut.r_ctr_col), 72'(me.col));
            chk("ctr_row", 72'(dut.r_ctr_row), 72'(me.row));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] ms;
      int eofs;
      model_reset();
      #12;
      chk_reset_state();
      @(negedge clk);
      rst_n = 1'b1;

      // Gapless frame with gaussian requested from IDLE.
      for (int k = 0; k < FRAME; k++) step(1'b1, 1'b1, 2'd1);
      repeat (3) step(1'b0, 1'b0, 2'd1);

      // Mid-frame request toggling 1 -> 3 -> 2; only the wrap-cycle value counts.
      for (int k = 0; k < FRAME; k++) begin
         ms = (k < 16) ? 2'd1 : ((k < 32) ? 2'd3 : 2'd2);
         step(1'b1, 1'b1, ms);
      end
      repeat (3) step(1'b0, 1'b1, 2'd0);

      // Random handshake gaps and random requests across three frames.
      eofs = 0;
      for (int c = 0; c < 3000 && eofs < 3; c++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         if (m_pos == 0 && sb.size() > 0 && sb[$].eof) eofs++;
      end
      for (int k = 0; k < FRAME && m_pos != 0; k++) step(1'b1, 1'b1, 2'd0);

      // Asynchronous reset in the middle of a frame (after 29 transfers).
      for (int k = 0; k < 29; k++) step(1'b1, 1'b1, 2'($urandom_range(0, 3)));
      @(negedge clk);
      in_valid = 1'b1; in_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_reset_state();
      in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < FRAME; k++) step(1'b1, 1'b1, 2'd3);
      step(1'b0, 1'b1, 2'd0);

      // Preload the frame counter to its top value and close one more frame.
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      m_fcnt = 16'hFFFF;
      step(1'b0, 1'b0, 2'd0);
      for (int k = 0; k < FRAME; k++) step(1'b1, 1'b1, 2'd2);
      repeat (3) step(1'b0, 1'b0, 2'd0);

      repeat (2) @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
